// File: rtl/fft_loader.sv
// fft_loader: bit-reversed frame loader with two-bank ping-pong handoff.
// Optional macro FFT_LOADER_SCALE_EN pre-scales each component by 1/N.
module fft_loader #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*width-1:0] in_data,
  output logic               wr_en,
  output logic [N_2:0]       wr_addr,
  output logic [2*width-1:0] wr_data,
  output logic               frame_valid,
  output logic               frame_bank,
  input  logic               frame_ack,
  output logic               overflow
);

  logic [N_2-1:0]     index, index_nxt;
  logic               wbank, wbank_nxt;
  logic               rbank, rbank_nxt;
  logic [1:0]         full, full_nxt;
  logic               pend, pend_nxt;
  logic               accept;
  logic               ack_ok;
  logic [2*width-1:0] data_f;

  function automatic logic [N_2-1:0] bitrev(
    input logic [N_2-1:0] v
  );
    logic [N_2-1:0] r;
    r = '0;
    for (int i = 0; i < N_2; i++)
      r[i] = v[N_2-1-i];
    return r;
  endfunction

`ifdef FFT_LOADER_SCALE_EN
  logic signed [width-1:0] re_s;
  logic signed [width-1:0] im_s;
  // Arithmetic shift floors toward -inf, giving 1/N headroom.
  assign re_s = $signed(in_data[2*width-1:width]) >>> N_2;
  assign im_s = $signed(in_data[width-1:0]) >>> N_2;
  assign data_f = {re_s, im_s};
`else
  assign data_f = in_data;
`endif

  assign in_ready    = !full[wbank] && !pend;
  assign accept      = in_valid && in_ready;
  assign ack_ok      = frame_ack && full[rbank];
  assign frame_valid = full[rbank];
  assign frame_bank  = rbank;

  // Next-state for frame position, bank pointers and occupancy.
  always_comb begin
    index_nxt = index;
    wbank_nxt = wbank ^ pend;
    rbank_nxt = rbank ^ ack_ok;
    full_nxt  = full;
    pend_nxt  = 1'b0;
    if (accept) begin
      index_nxt = index + 1'b1;
      pend_nxt  = (index == '1);
    end
    if (pend)
      full_nxt[wbank] = 1'b1;
    if (ack_ok)
      full_nxt[rbank] = 1'b0;
  end

  // Register control state and the RAM write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      index    <= '0;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      full     <= 2'b00;
      pend     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      index    <= index_nxt;
      wbank    <= wbank_nxt;
      rbank    <= rbank_nxt;
      full     <= full_nxt;
      pend     <= pend_nxt;
      wr_en    <= accept;
      overflow <= overflow | (in_valid & ~in_ready);
      if (accept) begin
        wr_addr <= {wbank, bitrev(index)};
        wr_data <= data_f;
      end
    end
  end

endmodule

// File: tb/tb_fft_loader.sv
// tb_fft_loader: randomized checks of fft_loader against a
// frame-counting reference model (N_2=3, width=16).
module tb_fft_loader;

  localparam int W = 16;
  localparam int L = 3;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] in_data = '0;
  logic          wr_en;
  logic [L:0]    wr_addr;
  logic [2*W-1:0] wr_data;
  logic          frame_valid;
  logic          frame_bank;
  logic          frame_ack = 1'b0;
  logic          overflow;

  fft_loader #(.width(W), .N_2(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_bank(frame_bank),
    .frame_ack(frame_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int m_cnt, m_done, m_acked;
  bit m_pend, m_ovf;
  logic           e_wr_en;
  logic [L:0]     e_addr;
  logic [2*W-1:0] e_data;

  function automatic int brev(int i);
    int r = 0;
    for (int b = 0; b < L; b++)
      if ((i / (1 << b)) % 2 == 1)
        r += 1 << (L - 1 - b);
    return r;
  endfunction

  function automatic bit m_ready();
    return !m_pend && (m_done - m_acked) < 2;
  endfunction

  function automatic logic [W-1:0] comp(logic [W-1:0] c);
`ifdef FFT_LOADER_SCALE_EN
    int v;
    int q;
    v = int'($signed(c));
    if (v >= 0) q = v / N;
    else q = -((-v + N - 1) / N);
    return q[W-1:0];
`else
    return c;
`endif
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_done = 0; m_acked = 0;
    m_pend = 0; m_ovf = 0;
    e_wr_en = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    frame_ack = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic cyc(input bit v, input logic [2*W-1:0] d,
                     input bit ack);
    bit rdy, fv, acc;
    in_valid = v; in_data = d; frame_ack = ack;
    rdy = m_ready();
    fv = m_done > m_acked;
    acc = v && rdy;
    @(posedge clk);
    if (v && !rdy) m_ovf = 1;
    e_wr_en = acc;
    if (m_pend) begin
      m_done++;
      m_pend = 0;
    end
    if (ack && fv) m_acked++;
    if (acc) begin
      e_addr = (L+1)'((m_done % 2) * N + brev(m_cnt));
      e_data = {comp(d[2*W-1:W]), comp(d[W-1:0])};
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt = 0;
        m_pend = 1;
      end
    end
    #1;
    in_valid = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    total++;
    if (frame_valid !== 1'b0 || frame_bank !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame got=%b/%b exp=0/0",
               frame_valid, frame_bank);
    end
    total++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      bad++;
      $display("FAIL reset_wr got=%b/%h/%h exp=0/0/0",
               wr_en, wr_addr, wr_data);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%b exp=0", overflow);
    end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, $urandom, 0);
    cyc(1, 32'h1234_5678, 0);
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 4'b0100) begin
      bad++;
      $display("FAIL single_addr got=%b/%b exp=1/0100",
               wr_en, wr_addr);
    end
    total++;
    if (wr_data !== e_data) begin
      bad++;
      $display("FAIL single_data got=%h exp=%h", wr_data, e_data);
    end
  endtask

  task automatic test_frame();
    logic [2:0] order [8];
    order = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    do_reset();
    for (int i = 0; i < N; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL frame_ready i=%0d got=%b exp=1", i, in_ready);
      end
      cyc(1, $urandom, 0);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== {1'b0, order[i]} ||
          wr_data !== e_data) begin
        bad++;
        $display("FAIL frame_wr i=%0d got=%b/%b/%h exp=1/0%b/%h",
                 i, wr_en, wr_addr, wr_data, order[i], e_data);
      end
    end
    total++;
    if (in_ready !== 1'b0 || frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_pend got=%b/%b exp=0/0",
               in_ready, frame_valid);
    end
    cyc(1, $urandom, 0);
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL frame_noacc got=%b exp=0", wr_en);
    end
    total++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_pub got=%b/%b/%b exp=1/0/1",
               frame_valid, frame_bank, in_ready);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL frame_pend_ovf got=%b exp=1", overflow);
    end
  endtask

  task automatic test_pingpong();
    int acc;
    int guard;
    do_reset();
    for (int i = 0; i < N; i++) cyc(1, $urandom, 0);
    cyc(0, 0, 0);
    acc = 0;
    guard = 0;
    while (acc < N && guard < 200) begin
      cyc(($urandom % 4) != 0, $urandom, 0);
      guard++;
      if (e_wr_en) begin
        acc++;
        total++;
        if (wr_en !== 1'b1 || wr_addr[3] !== 1'b1 ||
            wr_addr !== e_addr || wr_data !== e_data) begin
          bad++;
          $display("FAIL pp_wr got=%b/%b/%h exp=1/%b/%h",
                   wr_en, wr_addr, wr_data, e_addr, e_data);
        end
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    total++;
    if (in_ready !== 1'b0 || frame_valid !== 1'b1 ||
        overflow !== 1'b0) begin
      bad++;
      $display("FAIL pp_full got=%b/%b/%b exp=0/1/0",
               in_ready, frame_valid, overflow);
    end
    cyc(1, $urandom, 0);
    total++;
    if (overflow !== 1'b1 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL pp_ovf got=%b/%b exp=1/0", overflow, wr_en);
    end
    cyc(0, 0, 1);
    total++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1 ||
        in_ready !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL pp_ack got=%b/%b/%b/%b exp=1/1/1/1",
               frame_valid, frame_bank, in_ready, overflow);
    end
  endtask

  task automatic test_ack_publish();
    do_reset();
    for (int i = 0; i < N; i++) cyc(1, $urandom, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, $urandom, 0);
    cyc(0, 0, 1);
    total++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ackpub got=%b/%b/%b exp=1/1/1",
               frame_valid, frame_bank, in_ready);
    end
    cyc(0, 0, 1);
    total++;
    if (frame_valid !== 1'b0 || frame_bank !== 1'b0) begin
      bad++;
      $display("FAIL ackpub_empty got=%b/%b exp=0/0",
               frame_valid, frame_bank);
    end
    cyc(0, 0, 1);
    total++;
    if (frame_valid !== 1'b0 || frame_bank !== 1'b0) begin
      bad++;
      $display("FAIL ack_ignored got=%b/%b exp=0/0",
               frame_valid, frame_bank);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) cyc(1, $urandom, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, $urandom | 1, 0);
    do_reset();
    total++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
        in_ready !== 1'b1 || frame_valid !== 1'b0 ||
        frame_bank !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rstmid got=%b/%h/%h/%b/%b/%b/%b exp=0/0/0/1/0/0/0",
               wr_en, wr_addr, wr_data, in_ready, frame_valid,
               frame_bank, overflow);
    end
    cyc(1, $urandom, 0);
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_first got=%b/%b exp=1/0000", wr_en, wr_addr);
    end
  endtask

  task automatic test_scale();
    logic [31:0] exp;
`ifdef FFT_LOADER_SCALE_EN
    exp = 32'h0FFF_F000;
`else
    exp = 32'h7FF8_8000;
`endif
    do_reset();
    cyc(1, 32'h7FF8_8000, 0);
    total++;
    if (wr_data !== exp) begin
      bad++; $display("FAIL scale got=%h exp=%h", wr_data, exp);
    end
    cyc(1, 32'hFFFF_0009, 0);
    total++;
    if (wr_data !== e_data) begin
      bad++; $display("FAIL scale_neg got=%h exp=%h", wr_data, e_data);
    end
  endtask

  task automatic test_random();
    bit v, a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom % 3) != 0;
      a = ($urandom % 5) == 0;
      total++;
      if (in_ready !== m_ready()) begin
        bad++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b",
                 c, in_ready, m_ready());
      end
      cyc(v, $urandom, a);
      total++;
      if (wr_en !== e_wr_en || wr_addr !== e_addr ||
          wr_data !== e_data) begin
        bad++;
        $display("FAIL rnd_wr c=%0d got=%b/%h/%h exp=%b/%h/%h",
                 c, wr_en, wr_addr, wr_data, e_wr_en, e_addr, e_data);
      end
      total++;
      if (frame_valid !== (m_done > m_acked) ||
          frame_bank !== 1'(m_acked % 2) ||
          overflow !== m_ovf) begin
        bad++;
        $display("FAIL rnd_frame c=%0d got=%b/%b/%b exp=%b/%b/%b",
                 c, frame_valid, frame_bank, overflow,
                 m_done > m_acked, 1'(m_acked % 2), m_ovf);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_frame();
    test_pingpong();
    test_ack_publish();
    test_reset_mid();
    test_scale();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_loader.md
# fft_loader

Input stage of the FFT datapath. It accepts complex time-domain samples over a valid/ready stream and writes each frame of N = 2^N_2 samples into a two-bank sample RAM at bit-reversed addresses, so the in-place radix-2 core that follows reads its operands in natural butterfly order. It tracks bank occupancy as a two-entry ping-pong: it loads one bank while the FFT core processes the other, and it hands completed frames to the core with a valid/ack handshake.

## Interface
Parameters:
- width, 16, bits per real/imag component (Q1.(width-1) signed)
- N_2, 5, log2 of frame length N

Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  loader can accept a sample.
- in_data  in  2*width  sample packed as {re, im}, both signed.
- wr_en  out  1  sample RAM write strobe.
- wr_addr  out  N_2+1  RAM address: {bank, bitrev(index)}.
- wr_data  out  2*width  {re, im} written to RAM.
- frame_valid  out  1  a full bank is ready for the FFT core.
- frame_bank  out  1  bank index of the offered frame.
- frame_ack  in  1  core finished with frame_bank; releases it.
- overflow  out  1  sticky; set if in_valid is high while in_ready is low.

## Operation
State:
- index[N_2-1:0]: position within the frame being loaded.
- wbank: the bank being loaded.
- rbank: the bank offered to the core.
- full[1:0]: occupancy flag for each bank.
- pend: flag meaning "last write issued, bank not yet published".

Accept and write:
- in_ready = !full[wbank] && !pend.
- An accept is in_valid && in_ready.
- On each accept, the following are registered: wr_en=1, wr_addr={wbank, bitrev(index)}, wr_data=f(in_data). Then index increments.
- On a cycle with no accept, wr_en=0. wr_addr and wr_data hold their previous values.

Frame end:
- An accept with index==N-1 also wraps index to 0 and sets pend.
- On the next cycle, full[wbank] is set, wbank toggles, and pend clears.
- This guarantees the last RAM write lands before frame_valid rises.

Frame handoff:
- frame_valid = full[rbank]; frame_bank = rbank.
- frame_ack while frame_valid=1 clears full[rbank] and toggles rbank.
- frame_ack while frame_valid=0 is ignored.

Simultaneous events:
- Publish (setting full[wbank]) and ack (clearing full[rbank]) in the same cycle both take effect.
- These always target different banks, except when both banks were empty at publish. In that case no ack is possible, because frame_valid was 0.

Overflow:
- overflow sets when in_valid && !in_ready.
- It clears only on reset.

Data path:
- Without the scaling macro, f(in_data) = in_data unchanged.

## Timing
- Reset values, applied on the edge where reset_n=0 is sampled:
  - index=0, wbank=0, rbank=0, full=2'b00, pend=0.
  - wr_en=0, wr_addr=0, wr_data=0, overflow=0.
  - As a result: in_ready=1, frame_valid=0, frame_bank=0.
- Reset mid-frame discards the partial frame and both bank flags. RAM contents are not cleared.
- Write latency: wr_en is asserted 1 cycle after the accept edge.
- frame_valid rises 2 cycles after the accept edge of sample N-1.
- in_ready is low for exactly 1 cycle (the pend cycle) after every frame, even if the next bank is free. Back-to-back frames therefore take N+1 cycles each.
- in_ready is combinational from registered state only; it has no path from in_valid or frame_ack.
- frame_valid and frame_bank change only on clock edges.
- After frame_ack is sampled, frame_valid reflects the next bank on the next cycle.

## Configuration
- FFT_LOADER_SCALE_EN
  - Defined: each component is arithmetically shifted right by N_2 before writing:
    - re' = re >>> N_2; im' = im >>> N_2.
    - Truncation is toward −∞.
    - This pre-scales the data by 1/N so the log2(N) butterfly stages cannot overflow.
  - Undefined: data is written unmodified. Timing and handshake are identical in both builds.

## Test plan
All scenarios use N_2=3 (N=8) and width=16.
- Reset then single sample: in_data=32'h1234_5678 at index 1 -> one cycle later wr_en=1, wr_addr=4'b0100 (bitrev(001)=100), wr_data=32'h1234_5678.
- Full frame, continuous valid: indices 0..7 -> wr_addr low bits in order 0,4,2,6,1,5,3,7. in_ready=0 for 1 cycle after the 8th accept. frame_valid=1 with frame_bank=0 two cycles after the 8th accept.
- Ping-pong fill: load 2 frames with no ack -> frame 2 writes use addr bit 3=1. After that, in_ready stays 0. Holding in_valid=1 for 1 more cycle sets overflow=1. One frame_ack -> frame_bank=1 next cycle, and in_ready=1 for bank 0.
- Ack coinciding with publish: bank 0 full, and frame_ack asserted on the publish cycle of bank 1 -> next cycle full=2'b10, frame_valid=1, frame_bank=1.
- Reset mid-frame: assert reset_n=0 after 5 accepts -> outputs take reset values. The next accept writes wr_addr=0.
- With FFT_LOADER_SCALE_EN defined: in_data={16'h7FF8, 16'h8000} -> wr_data={16'h0FFF, 16'hF000}. With the macro undefined, the same input is written unchanged.
